mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle MIPS main controller; sits directly upstream of the ALU.
//  Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction and decodes opcode/funct into the ALU op.
//  Drives alu_en and alu_control, then waits on alu_done, so single- and multi-cycle ops (MULT/DIV) share one handshake.
//  Also drives PC, IR, register-file, memory and HI/LO mux selects.
// PARAMETERS
//  none (all encodings are fixed constants in mips_pkg)
// PORTS
//  clk           in   1  system clock, rising edge
//  rst           in   1  synchronous, active-high reset
//  opcode        in   6  IR[31:26]
//  funct         in   6  IR[5:0]
//  mem_ready     in   1  memory access completes this cycle
//  alu_done      in   1  ALU result/hi/lo valid this cycle
//  alu_zero      in   1  ALU result == 0 (valid with alu_done)
//  alu_overflow  in   1  signed overflow (valid with alu_done)
//  alu_en        out  1  ALU operation request
//  alu_control   out  4  0 ADD,1 SUB,2 AND,3 OR,4 NOR,5 SLT,6 SLL,7 SRL,8 MULT,9 DIV
//  alu_src_a     out  2  0 PC, 1 regA, 2 shamt
//  alu_src_b     out  2  0 regB, 1 const 4, 2 signext imm, 3 signext imm<<2
//  pc_en, pc_src out  1/2  PC load; pc_src 0 ALU result, 1 ALUOut, 2 jump target
//  iord          out  1  memory address: 0 PC, 1 ALUOut
//  mem_read      out  1  memory read request
//  mem_write     out  1  memory write request
//  ir_write      out  1  load IR
//  reg_write     out  1  register-file write
//  reg_dst       out  1  0 rt, 1 rd
//  mem_to_reg    out  2  0 ALUOut, 1 MDR, 2 HI, 3 LO
//  exception     out  1  one-cycle pulse: overflow or illegal instruction
// BEHAVIOUR
//  - Reset: state <= IDLE. While rst=1 all outputs are forced to 0 combinationally. IDLE -> FETCH on the next cycle.
//  - FETCH: mem_read=1, iord=0, alu_en=1, ADD, src_a=PC, src_b=4.
//    Stays in FETCH until mem_ready&&alu_done. On that cycle only: ir_write=1, pc_en=1, pc_src=0. Then -> DECODE.
//  - DECODE: alu_en=1, ADD, PC + (imm<<2) for the branch target. Waits on alu_done, then dispatches on opcode:
//    00 R-type->EXEC; 23 lw and 2B sw ->MEMADR; 04 beq->BRANCH; 08 addi->ADDIEX; 02 j->JUMP; others->EXC.
//  - EXEC: alu_control from funct:
//    20 ADD, 22 SUB, 24 AND, 25 OR, 27 NOR, 2A SLT, 00 SLL(src_a=2), 02 SRL(src_a=2), 18 MULT, 1A DIV.
//    10 mfhi and 12 mflo skip the ALU and go straight to RWB (mem_to_reg=2/3). Unknown funct -> EXC.
//  - ALU handshake: alu_en and alu_control held stable until alu_done=1, with no cycle limit.
//    Leave the state on the alu_done cycle; alu_en deasserts on the next cycle.
//  - EXEC exit: ADD/SUB with alu_overflow -> EXC. MULT/DIV -> FETCH (no reg write). Otherwise -> RWB.
//  - RWB: reg_write=1, reg_dst=1, 1 cycle -> FETCH.
//  - MEMADR: ADD, src_a=regA, src_b=imm; on done -> MEMRD for lw, MEMWR for sw.
//  - MEMRD: mem_read=1, iord=1; on mem_ready -> MEMWB.
//  - MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, 1 cycle.
//  - MEMWR: mem_write=1, iord=1; on mem_ready -> FETCH.
//  - BRANCH: SUB regA-regB. On the done cycle pc_en=alu_zero, pc_src=1; -> FETCH.
//  - ADDIEX: ADD regA+imm; overflow -> EXC, else -> ADDIWB (reg_write, rt, ALUOut) -> FETCH.
//  - JUMP: pc_en=1, pc_src=2, 1 cycle -> FETCH.
//  - EXC: exception=1, 1 cycle, no register/memory/PC write; -> FETCH.
//  - Every output not listed for a state is 0 in that state.
//  - rst mid-operation (including while waiting on alu_done/mem_ready): outputs 0 immediately, IDLE on the next edge.
// STRUCTURE
//  - mips_pkg: state encodings, opcode/funct constants, ALU op codes, src/mux select codes.
//  - Sub-module alu_decoder (combinational): {state class, funct} -> alu_control, alu_src_a.
// TESTING
//  1 Reset: rst=1 for 3 cycles -> all outputs 0; state IDLE then FETCH with mem_read=1.
//  2 add (funct 20): alu_done held low 2 cycles in EXEC -> alu_en/alu_control=0 stable; then RWB reg_write=1, reg_dst=1.
//  3 mult (funct 18): alu_done after 5 cycles -> alu_control=8 throughout; no reg_write; back to FETCH.
//  4 beq with alu_zero=1 -> pc_en=1, pc_src=1 on the done cycle; with alu_zero=0 -> pc_en=0.
//  5 lw with mem_ready delayed 3 cycles -> MEMRD holds iord=1; MEMWB reg_write=1, mem_to_reg=1.
//  6 add with alu_overflow=1, and opcode 3F -> exception pulse of 1 cycle, no reg_write, then FETCH.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: FSM states,
// opcode/funct values, ALU operation codes and datapath mux selects.
package mips_multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_RWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_EXC
    } state_t;

    // Which kind of ALU request the current state makes
    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_PC_ADD,
        CLS_RTYPE,
        CLS_REG_ADD,
        CLS_REG_SUB
    } alu_class_t;

    // How an R-type funct is handled in EXEC
    typedef enum logic [1:0] {
        FK_ALU,
        FK_HILO,
        FK_ILLEGAL
    } funct_kind_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_MULT = 4'd8;
    localparam logic [3:0] ALU_DIV  = 4'd9;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_REGA  = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [1:0] SRCB_REGB    = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_HI     = 2'd2;
    localparam logic [1:0] M2R_LO     = 2'd3;

    // Only signed add/subtract raise an overflow exception
    function automatic logic isOverflowChecked(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB);
    endfunction

    // MULT/DIV land in HI/LO, so they never write the register file
    function automatic logic isHiLoProducer(input logic [5:0] funct);
        return (funct == FN_MULT) || (funct == FN_DIV);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Bundle of the controller's instruction, memory and ALU handshake signals
// plus every datapath select it drives.
interface mips_multicycle_ctrl_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       alu_done;
    logic       alu_zero;
    logic       alu_overflow;

    logic       alu_en;
    logic [3:0] alu_control;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] mem_to_reg;
    logic       exception;

    modport master (
        input  opcode, funct, mem_ready, alu_done, alu_zero, alu_overflow,
        output alu_en, alu_control, alu_src_a, alu_src_b, pc_en, pc_src,
               iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, exception
    );

    modport slave (
        output opcode, funct, mem_ready, alu_done, alu_zero, alu_overflow,
        input  alu_en, alu_control, alu_src_a, alu_src_b, pc_en, pc_src,
               iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, exception
    );

endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: turns the requesting state's class and the
// funct field into the ALU op code and operand-A select.
module mips_multicycle_ctrl_alu_decoder
    import mips_multicycle_ctrl_pkg::*;
(
    input  alu_class_t  i_aluClass,
    input  logic [5:0]  i_funct,
    output logic [3:0]  o_aluControl,
    output logic [1:0]  o_aluSrcA,
    output funct_kind_t o_functKind
);

    logic [3:0] w_rtypeOp;
    logic [1:0] w_rtypeSrcA;

    // Classify the funct field and pick its ALU op; shifts take shamt as operand A
    always_comb begin
        w_rtypeOp   = ALU_ADD;
        w_rtypeSrcA = SRCA_REGA;
        o_functKind = FK_ALU;
        case (i_funct)
            FN_ADD:  w_rtypeOp = ALU_ADD;
            FN_SUB:  w_rtypeOp = ALU_SUB;
            FN_AND:  w_rtypeOp = ALU_AND;
            FN_OR:   w_rtypeOp = ALU_OR;
            FN_NOR:  w_rtypeOp = ALU_NOR;
            FN_SLT:  w_rtypeOp = ALU_SLT;
            FN_SLL: begin
                w_rtypeOp   = ALU_SLL;
                w_rtypeSrcA = SRCA_SHAMT;
            end
            FN_SRL: begin
                w_rtypeOp   = ALU_SRL;
                w_rtypeSrcA = SRCA_SHAMT;
            end
            FN_MULT: w_rtypeOp = ALU_MULT;
            FN_DIV:  w_rtypeOp = ALU_DIV;
            FN_MFHI, FN_MFLO: o_functKind = FK_HILO;
            default: o_functKind = FK_ILLEGAL;
        endcase
    end

    // Select the op for the requesting state: fixed adds/subtracts or the funct decode
    always_comb begin
        o_aluControl = ALU_ADD;
        o_aluSrcA    = SRCA_PC;
        case (i_aluClass)
            CLS_PC_ADD: begin
                o_aluControl = ALU_ADD;
                o_aluSrcA    = SRCA_PC;
            end
            CLS_RTYPE: begin
                o_aluControl = w_rtypeOp;
                o_aluSrcA    = w_rtypeSrcA;
            end
            CLS_REG_ADD: begin
                o_aluControl = ALU_ADD;
                o_aluSrcA    = SRCA_REGA;
            end
            CLS_REG_SUB: begin
                o_aluControl = ALU_SUB;
                o_aluSrcA    = SRCA_REGA;
            end
            default: begin
                o_aluControl = ALU_ADD;
                o_aluSrcA    = SRCA_PC;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller. Sequences each instruction through
// fetch/decode/execute/memory/writeback and drives the ALU request handshake
// (alu_en held until alu_done) plus all PC, IR, memory and register selects.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
(
    input logic                    clk,
    input logic                    rst,
    mips_multicycle_ctrl_if.master bus
);

    state_t      r_state;
    state_t      w_nextState;
    alu_class_t  w_aluClass;
    logic [3:0]  w_aluControl;
    logic [1:0]  w_aluSrcA;
    funct_kind_t w_functKind;

    mips_multicycle_ctrl_alu_decoder u_aluDecoder (
        .i_aluClass   (w_aluClass),
        .i_funct      (bus.funct),
        .o_aluControl (w_aluControl),
        .o_aluSrcA    (w_aluSrcA),
        .o_functKind  (w_functKind)
    );

    // State register; reset parks the controller in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Map each ALU-using state onto the kind of operation it requests
    always_comb begin
        w_aluClass = CLS_NONE;
        case (r_state)
            S_FETCH, S_DECODE:  w_aluClass = CLS_PC_ADD;
            S_EXEC:             w_aluClass = CLS_RTYPE;
            S_MEMADR, S_ADDIEX: w_aluClass = CLS_REG_ADD;
            S_BRANCH:           w_aluClass = CLS_REG_SUB;
            default:            w_aluClass = CLS_NONE;
        endcase
    end

    // Next-state logic; waiting states stay put until their handshake completes
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: w_nextState = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready && bus.alu_done) begin
                    w_nextState = S_DECODE;
                end
            end
            S_DECODE: begin
                if (bus.alu_done) begin
                    case (bus.opcode)
                        OP_RTYPE:     w_nextState = S_EXEC;
                        OP_LW, OP_SW: w_nextState = S_MEMADR;
                        OP_BEQ:       w_nextState = S_BRANCH;
                        OP_ADDI:      w_nextState = S_ADDIEX;
                        OP_J:         w_nextState = S_JUMP;
                        default:      w_nextState = S_EXC;
                    endcase
                end
            end
            S_EXEC: begin
                case (w_functKind)
                    FK_HILO:    w_nextState = S_RWB;
                    FK_ILLEGAL: w_nextState = S_EXC;
                    default: begin
                        if (bus.alu_done) begin
                            if (isOverflowChecked(bus.funct) && bus.alu_overflow) begin
                                w_nextState = S_EXC;
                            end else if (isHiLoProducer(bus.funct)) begin
                                w_nextState = S_FETCH;
                            end else begin
                                w_nextState = S_RWB;
                            end
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                if (bus.alu_done) begin
                    w_nextState = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
            end
            S_MEMRD: begin
                if (bus.mem_ready) begin
                    w_nextState = S_MEMWB;
                end
            end
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    w_nextState = S_FETCH;
                end
            end
            S_BRANCH: begin
                if (bus.alu_done) begin
                    w_nextState = S_FETCH;
                end
            end
            S_ADDIEX: begin
                if (bus.alu_done) begin
                    w_nextState = bus.alu_overflow ? S_EXC : S_ADDIWB;
                end
            end
            S_RWB, S_MEMWB, S_ADDIWB, S_JUMP, S_EXC: w_nextState = S_FETCH;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Datapath controls per state; everything is held low while reset is asserted
    always_comb begin
        bus.alu_en      = 1'b0;
        bus.alu_control = ALU_ADD;
        bus.alu_src_a   = SRCA_PC;
        bus.alu_src_b   = SRCB_REGB;
        bus.pc_en       = 1'b0;
        bus.pc_src      = PCSRC_ALU;
        bus.iord        = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = M2R_ALUOUT;
        bus.exception   = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    bus.alu_en      = 1'b1;
                    bus.alu_control = w_aluControl;
                    bus.alu_src_a   = w_aluSrcA;
                    bus.alu_src_b   = SRCB_FOUR;
                    bus.mem_read    = 1'b1;
                    if (bus.mem_ready && bus.alu_done) begin
                        bus.ir_write = 1'b1;
                        bus.pc_en    = 1'b1;
                        bus.pc_src   = PCSRC_ALU;
                    end
                end
                S_DECODE: begin
                    bus.alu_en      = 1'b1;
                    bus.alu_control = w_aluControl;
                    bus.alu_src_a   = w_aluSrcA;
                    bus.alu_src_b   = SRCB_IMM_SH2;
                end
                S_EXEC: begin
                    if (w_functKind == FK_ALU) begin
                        bus.alu_en      = 1'b1;
                        bus.alu_control = w_aluControl;
                        bus.alu_src_a   = w_aluSrcA;
                        bus.alu_src_b   = SRCB_REGB;
                    end
                end
                S_RWB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                    if (bus.funct == FN_MFHI) begin
                        bus.mem_to_reg = M2R_HI;
                    end else if (bus.funct == FN_MFLO) begin
                        bus.mem_to_reg = M2R_LO;
                    end
                end
                S_MEMADR, S_ADDIEX: begin
                    bus.alu_en      = 1'b1;
                    bus.alu_control = w_aluControl;
                    bus.alu_src_a   = w_aluSrcA;
                    bus.alu_src_b   = SRCB_IMM;
                end
                S_MEMRD: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                end
                S_MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = M2R_MDR;
                end
                S_MEMWR: begin
                    bus.mem_write = 1'b1;
                    bus.iord      = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_en      = 1'b1;
                    bus.alu_control = w_aluControl;
                    bus.alu_src_a   = w_aluSrcA;
                    bus.alu_src_b   = SRCB_REGB;
                    if (bus.alu_done) begin
                        bus.pc_en  = bus.alu_zero;
                        bus.pc_src = PCSRC_ALUOUT;
                    end
                end
                S_ADDIWB: begin
                    bus.reg_write = 1'b1;
                end
                S_JUMP: begin
                    bus.pc_en  = 1'b1;
                    bus.pc_src = PCSRC_JUMP;
                end
                S_EXC: begin
                    bus.exception = 1'b1;
                end
                default: begin
                    bus.alu_en = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl. Instructions are expanded into a
// cycle-by-cycle plan of stimulus and expected controls, then replayed.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       aluEn;
        logic [3:0] aluControl;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic       pcEn;
        logic [1:0] pcSrc;
        logic       iord;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regWrite;
        logic       regDst;
        logic [1:0] memToReg;
        logic       exception;
    } out_t;

    typedef struct {
        logic       rstVal;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       memReady;
        logic       aluDone;
        logic       aluZero;
        logic       aluOvf;
        out_t       exp;
        string      tag;
    } cyc_t;

    localparam out_t NONE = '0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         testCount = 0;
    int         failCount = 0;
    logic [5:0] curOp = 6'h00;
    logic [5:0] curFunct = 6'h00;
    cyc_t       plan[$];

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic rbit();
        return ($urandom() & 32'd1) != 0;
    endfunction

    function automatic out_t aluReq(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b);
        out_t e;
        e            = NONE;
        e.aluEn      = 1'b1;
        e.aluControl = op;
        e.aluSrcA    = a;
        e.aluSrcB    = b;
        return e;
    endfunction

    task automatic pushCycle(input string tag, input logic r, input logic mr, input logic ad,
                             input logic az, input logic ao, input out_t e);
        cyc_t c;
        c.rstVal   = r;
        c.opcode   = curOp;
        c.funct    = curFunct;
        c.memReady = mr;
        c.aluDone  = ad;
        c.aluZero  = az;
        c.aluOvf   = ao;
        c.exp      = e;
        c.tag      = tag;
        plan.push_back(c);
    endtask

    task automatic planAluWait(input string tag, input int lat, input out_t eWait, input out_t eDone,
                               input logic z, input logic o);
        for (int k = 0; k < lat; k++) begin
            pushCycle(tag, 1'b0, rbit(), 1'b0, rbit(), rbit(), eWait);
        end
        pushCycle({tag, " done"}, 1'b0, rbit(), 1'b1, z, o, eDone);
    endtask

    task automatic planMemWait(input string tag, input int lat, input out_t e);
        for (int k = 0; k < lat; k++) begin
            pushCycle(tag, 1'b0, 1'b0, rbit(), rbit(), rbit(), e);
        end
        pushCycle({tag, " ready"}, 1'b0, 1'b1, rbit(), rbit(), rbit(), e);
    endtask

    task automatic planFetch();
        int   lat;
        int   pick;
        out_t e;
        lat       = $urandom_range(0, 3);
        e         = aluReq(4'd0, 2'd0, 2'd1);
        e.memRead = 1'b1;
        for (int k = 0; k < lat; k++) begin
            pick = $urandom_range(0, 2);
            pushCycle("fetch", 1'b0, pick == 1, pick == 2, rbit(), rbit(), e);
        end
        e.irWrite = 1'b1;
        e.pcEn    = 1'b1;
        pushCycle("fetch done", 1'b0, 1'b1, 1'b1, rbit(), rbit(), e);
    endtask

    task automatic planExc();
        out_t e;
        e           = NONE;
        e.exception = 1'b1;
        pushCycle("exc", 1'b0, rbit(), rbit(), rbit(), rbit(), e);
    endtask

    task automatic planRType(input logic [5:0] fn, input int lat, input logic o);
        int   aop;
        out_t e;
        out_t w;
        case (fn)
            6'h20: aop = 0;
            6'h22: aop = 1;
            6'h24: aop = 2;
            6'h25: aop = 3;
            6'h27: aop = 4;
            6'h2A: aop = 5;
            6'h00: aop = 6;
            6'h02: aop = 7;
            6'h18: aop = 8;
            6'h1A: aop = 9;
            6'h10, 6'h12: aop = -2;
            default: aop = -1;
        endcase
        w          = NONE;
        w.regWrite = 1'b1;
        w.regDst   = 1'b1;
        if (aop >= 0) begin
            e = aluReq(4'(aop), (aop == 6 || aop == 7) ? 2'd2 : 2'd1, 2'd0);
            planAluWait("exec", lat, e, e, rbit(), o);
            if ((aop == 0 || aop == 1) && o) begin
                planExc();
            end else if (aop != 8 && aop != 9) begin
                pushCycle("rwb", 1'b0, rbit(), rbit(), rbit(), rbit(), w);
            end
        end else begin
            pushCycle("exec skip", 1'b0, rbit(), rbit(), rbit(), rbit(), NONE);
            if (aop == -2) begin
                w.memToReg = (fn == 6'h10) ? 2'd2 : 2'd3;
                pushCycle("rwb hilo", 1'b0, rbit(), rbit(), rbit(), rbit(), w);
            end else begin
                planExc();
            end
        end
    endtask

    task automatic planInstr(input logic [5:0] op, input logic [5:0] fn, input int aluLat,
                             input int memLat, input logic z, input logic o);
        out_t e;
        out_t d;
        curOp    = op;
        curFunct = fn;
        planFetch();
        e = aluReq(4'd0, 2'd0, 2'd3);
        planAluWait("decode", $urandom_range(0, 2), e, e, rbit(), rbit());
        case (op)
            6'h00: planRType(fn, aluLat, o);
            6'h23, 6'h2B: begin
                e = aluReq(4'd0, 2'd1, 2'd2);
                planAluWait("memadr", aluLat, e, e, rbit(), rbit());
                e      = NONE;
                e.iord = 1'b1;
                if (op == 6'h23) begin
                    e.memRead = 1'b1;
                    planMemWait("memrd", memLat, e);
                    e          = NONE;
                    e.regWrite = 1'b1;
                    e.memToReg = 2'd1;
                    pushCycle("memwb", 1'b0, rbit(), rbit(), rbit(), rbit(), e);
                end else begin
                    e.memWrite = 1'b1;
                    planMemWait("memwr", memLat, e);
                end
            end
            6'h04: begin
                e       = aluReq(4'd1, 2'd1, 2'd0);
                d       = e;
                d.pcEn  = z;
                d.pcSrc = 2'd1;
                planAluWait("branch", aluLat, e, d, z, rbit());
            end
            6'h08: begin
                e = aluReq(4'd0, 2'd1, 2'd2);
                planAluWait("addiex", aluLat, e, e, rbit(), o);
                if (o) begin
                    planExc();
                end else begin
                    e          = NONE;
                    e.regWrite = 1'b1;
                    pushCycle("addiwb", 1'b0, rbit(), rbit(), rbit(), rbit(), e);
                end
            end
            6'h02: begin
                e       = NONE;
                e.pcEn  = 1'b1;
                e.pcSrc = 2'd2;
                pushCycle("jump", 1'b0, rbit(), rbit(), rbit(), rbit(), e);
            end
            default: planExc();
        endcase
    endtask

    task automatic planReset(input int n);
        for (int k = 0; k < n; k++) begin
            pushCycle("reset", 1'b1, rbit(), rbit(), rbit(), rbit(), NONE);
        end
        pushCycle("idle", 1'b0, rbit(), rbit(), rbit(), rbit(), NONE);
    endtask

    task automatic applyStimulus(input cyc_t c);
        @(negedge clk);
        rst              = c.rstVal;
        bus.opcode       = c.opcode;
        bus.funct        = c.funct;
        bus.mem_ready    = c.memReady;
        bus.alu_done     = c.aluDone;
        bus.alu_zero     = c.aluZero;
        bus.alu_overflow = c.aluOvf;
    endtask

    task automatic checkOutput(input cyc_t c);
        out_t obs;
        #1;
        obs.aluEn      = bus.alu_en;
        obs.aluControl = bus.alu_control;
        obs.aluSrcA    = bus.alu_src_a;
        obs.aluSrcB    = bus.alu_src_b;
        obs.pcEn       = bus.pc_en;
        obs.pcSrc      = bus.pc_src;
        obs.iord       = bus.iord;
        obs.memRead    = bus.mem_read;
        obs.memWrite   = bus.mem_write;
        obs.irWrite    = bus.ir_write;
        obs.regWrite   = bus.reg_write;
        obs.regDst     = bus.reg_dst;
        obs.memToReg   = bus.mem_to_reg;
        obs.exception  = bus.exception;
        testCount++;
        assert (obs === c.exp) else begin
            failCount++;
            $error("FAIL %s op=%h fn=%h: observed %h expected %h", c.tag, c.opcode, c.funct, obs, c.exp);
        end
    endtask

    initial begin
        cyc_t c;
        bus.opcode       = 6'h00;
        bus.funct        = 6'h00;
        bus.mem_ready    = 1'b0;
        bus.alu_done     = 1'b0;
        bus.alu_zero     = 1'b0;
        bus.alu_overflow = 1'b0;

        // Reset held 3 cycles, then IDLE, then fetch
        planReset(3);
        // add with ALU done delayed 2 cycles in EXEC
        planInstr(6'h00, 6'h20, 2, 0, 1'b0, 1'b0);
        // mult finishing after 5 wait cycles
        planInstr(6'h00, 6'h18, 5, 0, 1'b0, 1'b0);
        // beq taken and not taken
        planInstr(6'h04, 6'h00, 1, 0, 1'b1, 1'b0);
        planInstr(6'h04, 6'h00, 0, 0, 1'b0, 1'b0);
        // lw with memory 3 cycles late
        planInstr(6'h23, 6'h00, 1, 3, 1'b0, 1'b0);
        // add overflow, then illegal opcode
        planInstr(6'h00, 6'h20, 0, 0, 1'b0, 1'b1);
        planInstr(6'h3F, 6'h00, 0, 0, 1'b0, 1'b0);
        // Remaining instruction classes
        planInstr(6'h2B, 6'h00, 2, 2, 1'b0, 1'b0);
        planInstr(6'h08, 6'h00, 1, 0, 1'b0, 1'b1);
        planInstr(6'h08, 6'h00, 1, 0, 1'b0, 1'b0);
        planInstr(6'h02, 6'h00, 0, 0, 1'b0, 1'b0);
        planInstr(6'h00, 6'h10, 0, 0, 1'b0, 1'b0);
        planInstr(6'h00, 6'h12, 0, 0, 1'b0, 1'b0);
        planInstr(6'h00, 6'h00, 1, 0, 1'b0, 1'b1);
        planInstr(6'h00, 6'h3F, 0, 0, 1'b0, 1'b0);
        planInstr(6'h00, 6'h22, 1, 0, 1'b0, 1'b1);
        // Reset while a mult is waiting on the ALU
        curOp    = 6'h00;
        curFunct = 6'h18;
        planFetch();
        pushCycle("decode", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, aluReq(4'd0, 2'd0, 2'd3));
        pushCycle("exec wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, aluReq(4'd8, 2'd1, 2'd0));
        pushCycle("exec wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, aluReq(4'd8, 2'd1, 2'd0));
        pushCycle("mid reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, NONE);
        pushCycle("idle after reset", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, NONE);
        // Randomized instruction mix
        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            logic [5:0] fnList [12];
            int         sel;
            int         idx;
            fnList = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A,
                       6'h00, 6'h02, 6'h18, 6'h1A, 6'h10, 6'h12};
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: op = 6'h00;
                4:          op = 6'h23;
                5:          op = 6'h2B;
                6:          op = 6'h04;
                7:          op = 6'h08;
                8:          op = 6'h02;
                default:    op = 6'($urandom());
            endcase
            idx = $urandom_range(0, 12);
            fn  = (idx == 12) ? 6'($urandom()) : fnList[idx];
            planInstr(op, fn, $urandom_range(0, 4), $urandom_range(0, 3), rbit(), rbit());
        end

        while (plan.size() > 0) begin
            c = plan.pop_front();
            applyStimulus(c);
            checkOutput(c);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
